// File: rtl/ldpc_ber_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_ber_pkg
// Shared constants and a helper for the LDPC BER tester result stage.
//   LDPC_BER_DOUT_WIDTH     default decoder output beat width (bits)
//   LDPC_BER_CNT_WIDTH      default block / bit-error accumulator width
//   LDPC_BER_INFLIGHT_WIDTH default in-flight counter width
//   LDPC_BER_POPCNT_CHUNK   bits per popcount lane
//   LDPC_BER_PART_W         width of one lane's partial count (0..32 -> 6 bits)
//   LDPC_BER_LANES          lane count for the default beat width
// ---------------------------------------------------------------------------
package ldpc_ber_pkg;

  localparam int LDPC_BER_DOUT_WIDTH     = 128;
  localparam int LDPC_BER_CNT_WIDTH      = 64;
  localparam int LDPC_BER_INFLIGHT_WIDTH = 32;
  localparam int LDPC_BER_POPCNT_CHUNK   = 32;
  localparam int LDPC_BER_PART_W         = $clog2(LDPC_BER_POPCNT_CHUNK + 1);
  localparam int LDPC_BER_LANES          = LDPC_BER_DOUT_WIDTH / LDPC_BER_POPCNT_CHUNK;

  // Number of ones in one 32-bit lane.
  function automatic logic [LDPC_BER_PART_W-1:0] ldpc_ber_popcount32(
    input logic [LDPC_BER_POPCNT_CHUNK-1:0] v
  );
    logic [LDPC_BER_PART_W-1:0] c;
    c = '0;
    for (int i = 0; i < LDPC_BER_POPCNT_CHUNK; i++) begin
      c = c + {{(LDPC_BER_PART_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ldpc_ber_popcount.sv
// ---------------------------------------------------------------------------
// ldpc_ber_popcount
// One register stage that turns a WIDTH-bit word into WIDTH/32 partial
// popcounts, carrying a valid/last sideband alongside.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   in_valid, in_last  sideband of the incoming word
//   in_data            word to count (WIDTH bits, WIDTH a multiple of 32)
//   out_valid/out_last registered sideband
//   out_partials       registered per-lane counts, lane l at [l*PART_W +: PART_W]
// ---------------------------------------------------------------------------
module ldpc_ber_popcount
  import ldpc_ber_pkg::*;
#(
  parameter int WIDTH = LDPC_BER_DOUT_WIDTH
) (
  input  logic                                                      clk,
  input  logic                                                      resetn,
  input  logic                                                      in_valid,
  input  logic                                                      in_last,
  input  logic [WIDTH-1:0]                                          in_data,
  output logic                                                      out_valid,
  output logic                                                      out_last,
  output logic [(WIDTH/LDPC_BER_POPCNT_CHUNK)*LDPC_BER_PART_W-1:0]  out_partials
);

  localparam int LANES = WIDTH / LDPC_BER_POPCNT_CHUNK;
  localparam int PW    = LDPC_BER_PART_W;
  localparam int CH    = LDPC_BER_POPCNT_CHUNK;

  logic                  valid_d, valid_q;
  logic                  last_d, last_q;
  logic [LANES*PW-1:0]   part_d, part_q;

  always_comb begin
    valid_d = in_valid;
    // last only means something together with valid
    last_d  = in_valid & in_last;
    part_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      part_d[l*PW +: PW] = ldpc_ber_popcount32(in_data[l*CH +: CH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      part_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      part_q  <= part_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign out_partials = part_q;

endmodule

// File: rtl/ldpc_ber_error_counter.sv
// ---------------------------------------------------------------------------
// ldpc_ber_error_counter
// Result stage of the LDPC BER tester. The transmitted codeword is all-zero,
// so every 1 in the decoder's hard-decision output is a residual bit error.
// Three-stage pipeline: mask -> per-lane popcount -> accumulate, so a beat
// accepted in cycle T shows on the outputs in cycle T+3.
// Ports:
//   data_clk, data_sw_resetn  clock, synchronous active-low reset
//   data_last_mask            on tlast beats, only bits set here are counted
//   din_tvalid/tready/tlast   decoder input stream, observed only
//   s_dout_*                  decoder output stream (sink, never backpressures)
//   data_finished_blocks      completed blocks (wraps)
//   data_bit_errors           accumulated error bits (wraps)
//   data_in_flight            blocks inside the decoder (saturating 0..max)
//
// Handshake: a dout beat transfers on a rising edge where s_dout_tvalid and
// s_dout_tready are both 1; tready is 0 in reset and 1 from the first cycle
// after reset, so the source never has to hold data. The din stream is only
// watched: a din block is counted when tvalid, tready and tlast are all 1.
// ---------------------------------------------------------------------------
module ldpc_ber_error_counter
  import ldpc_ber_pkg::*;
#(
  parameter int DOUT_WIDTH     = LDPC_BER_DOUT_WIDTH,
  parameter int CNT_WIDTH      = LDPC_BER_CNT_WIDTH,
  parameter int INFLIGHT_WIDTH = LDPC_BER_INFLIGHT_WIDTH
) (
  input  logic                      data_clk,
  input  logic                      data_sw_resetn,
  input  logic [DOUT_WIDTH-1:0]     data_last_mask,
  input  logic                      din_tvalid,
  input  logic                      din_tready,
  input  logic                      din_tlast,
  input  logic                      s_dout_tvalid,
  output logic                      s_dout_tready,
  input  logic [DOUT_WIDTH-1:0]     s_dout_tdata,
  input  logic                      s_dout_tlast,
  output logic [CNT_WIDTH-1:0]      data_finished_blocks,
  output logic [CNT_WIDTH-1:0]      data_bit_errors,
  output logic [INFLIGHT_WIDTH-1:0] data_in_flight
);

  localparam int LANES = DOUT_WIDTH / LDPC_BER_POPCNT_CHUNK;
  localparam int PW    = LDPC_BER_PART_W;
  localparam int SUM_W = $clog2(DOUT_WIDTH + 1);

  logic                      tready_d, tready_q;
  logic                      s1_valid_d, s1_valid_q;
  logic                      s1_last_d, s1_last_q;
  logic [DOUT_WIDTH-1:0]     s1_data_d, s1_data_q;
  logic [CNT_WIDTH-1:0]      finished_d, finished_q;
  logic [CNT_WIDTH-1:0]      bit_errors_d, bit_errors_q;
  logic [INFLIGHT_WIDTH-1:0] in_flight_d, in_flight_q;

  logic                      s2_valid;
  logic                      s2_last;
  logic [LANES*PW-1:0]       s2_partials;

  logic                      accept;
  logic                      din_block;
  logic                      dout_block;
  logic [SUM_W-1:0]          beat_sum;

  // Stage 1: accept and mask
  always_comb begin
    tready_d   = 1'b1;
    accept     = s_dout_tvalid & tready_q;
    s1_valid_d = accept;
    s1_last_d  = accept & s_dout_tlast;
    s1_data_d  = '0;
    if (accept) begin
      // Unused tail bits of a block live only on its last beat.
      s1_data_d = s_dout_tdata & (s_dout_tlast ? data_last_mask : {DOUT_WIDTH{1'b1}});
    end
  end

  // Stage 2: per-lane popcount
  ldpc_ber_popcount #(
    .WIDTH(DOUT_WIDTH)
  ) u_popcount (
    .clk          (data_clk),
    .resetn       (data_sw_resetn),
    .in_valid     (s1_valid_q),
    .in_last      (s1_last_q),
    .in_data      (s1_data_q),
    .out_valid    (s2_valid),
    .out_last     (s2_last),
    .out_partials (s2_partials)
  );

  // Stage 3: accumulate
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + SUM_W'(s2_partials[l*PW +: PW]);
    end
    bit_errors_d = bit_errors_q;
    finished_d   = finished_q;
    if (s2_valid) begin
      bit_errors_d = bit_errors_q + CNT_WIDTH'(beat_sum);
      if (s2_last) begin
        finished_d = finished_q + CNT_WIDTH'(1);
      end
    end
  end

  // In-flight tracking works on raw handshakes, not on the pipeline, so it
  // reacts in the same cycle the dout block leaves the decoder.
  always_comb begin
    din_block   = din_tvalid & din_tready & din_tlast;
    dout_block  = accept & s_dout_tlast;
    in_flight_d = in_flight_q;
    if (din_block && !dout_block && !(&in_flight_q)) begin
      in_flight_d = in_flight_q + INFLIGHT_WIDTH'(1);
    end else if (dout_block && !din_block && (in_flight_q != '0)) begin
      in_flight_d = in_flight_q - INFLIGHT_WIDTH'(1);
    end
  end

  always_ff @(posedge data_clk) begin
    if (!data_sw_resetn) begin
      tready_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_data_q    <= '0;
      finished_q   <= '0;
      bit_errors_q <= '0;
      in_flight_q  <= '0;
    end else begin
      tready_q     <= tready_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_data_q    <= s1_data_d;
      finished_q   <= finished_d;
      bit_errors_q <= bit_errors_d;
      in_flight_q  <= in_flight_d;
    end
  end

  assign s_dout_tready        = tready_q;
  assign data_finished_blocks = finished_q;
  assign data_bit_errors      = bit_errors_q;
  assign data_in_flight       = in_flight_q;

endmodule

// File: tb/tb_ldpc_ber_error_counter.sv
// ---------------------------------------------------------------------------
// tb_ldpc_ber_error_counter
// Self-checking bench. The main instance (128/64/32) is compared every cycle
// against a reference model built from the block's rules: each accepted beat
// contributes $countones(data & mask-if-last) errors that become visible two
// edges after acceptance; in-flight moves by whole handshakes and clamps at
// its range. A small instance (32/8/3) checks counter wrap and in-flight
// saturation with fixed expected numbers.
// ---------------------------------------------------------------------------
module tb_ldpc_ber_error_counter;

  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic          resetn;
  logic [W-1:0]  last_mask;
  logic          din_tvalid, din_tready, din_tlast;
  logic          s_dout_tvalid, s_dout_tready, s_dout_tlast;
  logic [W-1:0]  s_dout_tdata;
  logic [63:0]   finished, bit_errors;
  logic [31:0]   in_flight;

  ldpc_ber_error_counter dut (
    .data_clk             (clk),
    .data_sw_resetn       (resetn),
    .data_last_mask       (last_mask),
    .din_tvalid           (din_tvalid),
    .din_tready           (din_tready),
    .din_tlast            (din_tlast),
    .s_dout_tvalid        (s_dout_tvalid),
    .s_dout_tready        (s_dout_tready),
    .s_dout_tdata         (s_dout_tdata),
    .s_dout_tlast         (s_dout_tlast),
    .data_finished_blocks (finished),
    .data_bit_errors      (bit_errors),
    .data_in_flight       (in_flight)
  );

  // ---------------- small DUT for wrap / saturation ----------------
  logic        b_resetn;
  logic [31:0] b_mask, b_tdata;
  logic        b_din_v, b_din_r, b_din_l;
  logic        b_tvalid, b_tready, b_tlast;
  logic [7:0]  b_fin, b_err;
  logic [2:0]  b_if;

  ldpc_ber_error_counter #(
    .DOUT_WIDTH     (32),
    .CNT_WIDTH      (8),
    .INFLIGHT_WIDTH (3)
  ) dut_small (
    .data_clk             (clk),
    .data_sw_resetn       (b_resetn),
    .data_last_mask       (b_mask),
    .din_tvalid           (b_din_v),
    .din_tready           (b_din_r),
    .din_tlast            (b_din_l),
    .s_dout_tvalid        (b_tvalid),
    .s_dout_tready        (b_tready),
    .s_dout_tdata         (b_tdata),
    .s_dout_tlast         (b_tlast),
    .data_finished_blocks (b_fin),
    .data_bit_errors      (b_err),
    .data_in_flight       (b_if)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int due;
    int errs;
    bit last;
  } pend_t;

  pend_t       exp_q[$];
  logic [63:0] m_fin, m_err;
  logic [31:0] m_if;
  bit          m_ready;
  int          edge_n;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [63:0] f, input logic [63:0] e,
                            input logic [31:0] i);
    check_eq({tag, "_fin"}, finished, f);
    check_eq({tag, "_err"}, bit_errors, e);
    check_eq({tag, "_inflight"}, in_flight, i);
  endtask

  // One clock: model the edge from the inputs the DUT saw, then compare.
  task automatic step();
    bit acc, inc, dec;
    @(posedge clk);
    acc = s_dout_tvalid && m_ready;
    if (!resetn) begin
      exp_q.delete();
      m_fin   = '0;
      m_err   = '0;
      m_if    = '0;
      m_ready = 1'b0;
    end else begin
      if (acc) begin
        exp_q.push_back('{due: edge_n + 2,
                          errs: $countones(s_dout_tdata & (s_dout_tlast ? last_mask : {W{1'b1}})),
                          last: s_dout_tlast});
      end
      inc = din_tvalid && din_tready && din_tlast;
      dec = acc && s_dout_tlast;
      if (inc && !dec && m_if != 32'hFFFF_FFFF) m_if = m_if + 1;
      else if (dec && !inc && m_if != 0)        m_if = m_if - 1;
      while (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
        m_err = m_err + 64'(exp_q[0].errs);
        if (exp_q[0].last) m_fin = m_fin + 1;
        void'(exp_q.pop_front());
      end
      m_ready = 1'b1;
    end
    edge_n++;
    #1;
    check_eq("cyc_tready", s_dout_tready, m_ready);
    check_eq("cyc_fin", finished, m_fin);
    check_eq("cyc_err", bit_errors, m_err);
    check_eq("cyc_inflight", in_flight, m_if);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    s_dout_tvalid = 1'b0;
    s_dout_tlast  = 1'b0;
    s_dout_tdata  = '0;
    din_tvalid    = 1'b0;
    din_tready    = 1'b0;
    din_tlast     = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l);
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = d;
    s_dout_tlast  = l;
    step();
    drive_idle();
  endtask

  task automatic do_reset();
    drive_idle();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [W-1:0] five_bits();
    logic [W-1:0] v;
    v = '0;
    while ($countones(v) < 5) v[$urandom_range(0, W-1)] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: v = '0;
      1: v = v & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ones;
    ones      = {W{1'b1}};
    resetn    = 1'b0;
    last_mask = ones;
    drive_idle();
    b_resetn = 1'b0; b_mask = '1; b_tdata = '0;
    b_din_v = 1'b0; b_din_r = 1'b0; b_din_l = 1'b0;
    b_tvalid = 1'b0; b_tlast = 1'b0;
    m_fin = '0; m_err = '0; m_if = '0; m_ready = 1'b0; edge_n = 0;

    // Reset state
    step();
    step();
    check_eq("rst_tready", s_dout_tready, 1'b0);
    check_outs("rst", 64'd0, 64'd0, 32'd0);

    // Ready rises on the first cycle after release; single clean block
    resetn = 1'b1;
    step();
    check_eq("rel_tready", s_dout_tready, 1'b1);
    beat('0, 1'b1);
    idle(2);
    check_outs("single_blk", 64'd1, 64'd0, 32'd0);

    // Three all-ones beats, last beat masked to 16 bits
    do_reset();
    last_mask = 128'h0000_FFFF;
    beat(ones, 1'b0);
    beat(ones, 1'b0);
    beat(ones, 1'b1);
    check_eq("blk3_fin_e0", finished, 64'd0);
    step();
    check_eq("blk3_fin_e1", finished, 64'd0);
    step();
    check_outs("blk3", 64'd1, 64'd272, 32'd0);

    // 1000 back-to-back blocks, 5 error bits each
    do_reset();
    last_mask = ones;
    for (int i = 0; i < 1000; i++) begin
      s_dout_tvalid = 1'b1;
      s_dout_tlast  = 1'b1;
      s_dout_tdata  = five_bits();
      step();
    end
    idle(2);
    check_outs("b2b", 64'd1000, 64'd5000, 32'd0);

    // In-flight bookkeeping
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din_tvalid = 1'b1; din_tready = 1'b1; din_tlast = 1'b1;
      step();
    end
    drive_idle();
    check_eq("if_four", in_flight, 32'd4);
    din_tvalid = 1'b1; din_tready = 1'b1; din_tlast = 1'b1;
    beat('0, 1'b1);
    check_eq("if_both", in_flight, 32'd4);
    for (int i = 0; i < 4; i++) beat('0, 1'b1);
    check_eq("if_zero", in_flight, 32'd0);
    beat('0, 1'b1);
    check_eq("if_underflow", in_flight, 32'd0);
    // din handshake without tlast or without tready does not count
    din_tvalid = 1'b1; din_tready = 1'b0; din_tlast = 1'b1;
    step();
    din_tready = 1'b1; din_tlast = 1'b0;
    step();
    drive_idle();
    check_eq("if_partial_hs", in_flight, 32'd0);

    // Reset with two error beats still in the pipeline
    do_reset();
    beat(ones, 1'b0);
    beat(ones, 1'b0);
    resetn = 1'b0;
    step();
    check_eq("midrst_tready", s_dout_tready, 1'b0);
    check_outs("midrst", 64'd0, 64'd0, 32'd0);
    resetn = 1'b1;
    step();
    beat('0, 1'b1);
    idle(2);
    check_outs("after_midrst", 64'd1, 64'd0, 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      resetn        = ($urandom_range(0, 299) != 0);
      s_dout_tvalid = ($urandom_range(0, 3) != 0);
      s_dout_tlast  = ($urandom_range(0, 3) == 0);
      s_dout_tdata  = rand_word();
      din_tvalid    = ($urandom_range(0, 1) == 1);
      din_tready    = ($urandom_range(0, 3) != 0);
      din_tlast     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) last_mask = rand_word();
      step();
    end
    resetn = 1'b1;
    idle(3);

    // Small instance: 8-bit wrap and 3-bit in-flight saturation
    b_resetn = 1'b0;
    step();
    b_resetn = 1'b1;
    step();
    b_tvalid = 1'b1; b_tlast = 1'b1; b_tdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) step();
    b_tdata = 32'h7FFF_FFFF;
    step();
    b_tvalid = 1'b0; b_tlast = 1'b0;
    step(); step(); step();
    check_eq("small_err_255", b_err, 8'd255);
    check_eq("small_fin_8", b_fin, 8'd8);
    b_tvalid = 1'b1; b_tlast = 1'b1; b_tdata = 32'h0000_03FF;
    step();
    b_tvalid = 1'b0; b_tlast = 1'b0;
    step(); step(); step();
    check_eq("small_err_wrap", b_err, 8'd9);
    check_eq("small_fin_9", b_fin, 8'd9);
    b_din_v = 1'b1; b_din_r = 1'b1; b_din_l = 1'b1;
    for (int i = 0; i < 9; i++) step();
    b_din_v = 1'b0;
    step();
    check_eq("small_if_sat", b_if, 3'd7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldpc_ber_error_counter.md
Name: ldpc_ber_error_counter

Overview:
Data-clock result stage of the LDPC BER tester. Monitors the SD-FEC decoder output stream and counts residual bit errors against the all-zero transmitted codeword, masking unused bits on each block's last beat. Counts completed blocks and blocks currently in flight. Its outputs feed the regmap's feedback CDC: data_finished_blocks, data_bit_errors and data_in_flight.

Parameters:
DOUT_WIDTH, 128, decoder output beat width in bits; must be a multiple of 32.
CNT_WIDTH, 64, width of the block and bit-error accumulators.
INFLIGHT_WIDTH, 32, width of the in-flight counter.

Ports:
data_clk  in  1  data clock; all logic runs on it.
data_sw_resetn  in  1  synchronous, active-low reset.
data_last_mask  in  DOUT_WIDTH  on a tlast beat, a 1 means the bit is counted; quasi-static.
din_tvalid  in  1  decoder input stream valid (monitor only).
din_tready  in  1  decoder input stream ready (monitor only).
din_tlast  in  1  decoder input stream last (monitor only).
s_dout_tvalid  in  1  decoder hard-decision output valid.
s_dout_tready  out  1  always-accept ready.
s_dout_tdata  in  DOUT_WIDTH  decoded bits; any 1 is an error.
s_dout_tlast  in  1  last beat of a block.
data_finished_blocks  out  CNT_WIDTH  completed decoded blocks.
data_bit_errors  out  CNT_WIDTH  accumulated error bits.
data_in_flight  out  INFLIGHT_WIDTH  blocks accepted by the decoder but not yet output.

Behaviour:
- Clock and reset: one clock, data_clk. Reset is data_sw_resetn, synchronous and active-low.
- While data_sw_resetn=0, every register is cleared:
  - all counters 0;
  - s_dout_tready 0;
  - pipeline valids 0.
- s_dout_tready is registered. It is 0 in reset and 1 from the first cycle after reset releases. There is never backpressure.
- A beat is accepted when s_dout_tvalid & s_dout_tready.
- Stage 1 (T+1): register masked = tdata & (tlast ? data_last_mask : all-ones), plus valid and last.
- Stage 2 (T+2): ldpc_ber_popcount produces DOUT_WIDTH/32 registered partial counts, each 6 bits (0..32).
- Stage 3 (T+3):
  - sum the partials, zero-extend, and add to data_bit_errors;
  - if the beat was a tlast beat, increment data_finished_blocks in the same cycle.
- Latency: a beat accepted at cycle T is visible on the outputs at T+3. Back-to-back beats are fully pipelined, one per cycle.
- A multi-beat block accumulates errors per beat. finished_blocks changes only on the last beat.
- Accumulators wrap modulo 2^CNT_WIDTH. They do not saturate.
- data_in_flight:
  - increment when din_tvalid & din_tready & din_tlast;
  - decrement when an accepted dout beat has tlast; this is sampled at acceptance and does not wait for the pipeline;
  - if both occur in the same cycle, the value is unchanged;
  - a decrement at 0 holds 0 (underflow protection);
  - an increment at all-ones holds all-ones.
- Reset mid-block: the pipeline is flushed and partial errors are discarded. The next accepted beat is treated as the start of a new block.
- A data_last_mask change mid-run takes effect on the next tlast beat sampled at stage 1. No hazard handling is required.
- All outputs are direct register outputs with no combinational path from inputs. Exception: s_dout_tready, which is registered but constant.

Decomposition:
- Package ldpc_ber_pkg holds the shared constants:
  - LDPC_BER_DOUT_WIDTH=128;
  - LDPC_BER_CNT_WIDTH=64;
  - LDPC_BER_POPCNT_CHUNK=32;
  - the derived partial-sum width (6) and lane count (DOUT_WIDTH/32).
- Sub-module ldpc_ber_popcount: parameterised WIDTH input and registered per-32-bit partial outputs with a valid/last sideband. It is reused for stage 2.

Test Plan:
- Reset release, then one single-beat block, tdata=0, tlast=1 -> tready=1 on cycle 1; at T+3 finished_blocks=1, bit_errors=0.
- Three beats with tdata=all-ones, last beat tlast=1, data_last_mask=128'h0000_FFFF -> bit_errors=128+128+16=272, finished_blocks=1; finished_blocks changes only at T_last+3.
- 1000 back-to-back single-beat blocks, each with tdata having exactly 5 bits set -> bit_errors=5000, finished_blocks=1000, no idle bubbles needed.
- In-flight:
  - 4 din tlast handshakes -> in_flight=4;
  - a cycle with a din tlast and a dout tlast together -> stays 4;
  - 4 dout tlast beats -> 0;
  - an extra dout tlast -> stays 0.
- Reset in the middle of a 3-beat block after 2 beats (errors pending in the pipeline) -> all outputs 0 the cycle after reset. A subsequent clean 1-beat block with tdata=0 gives finished=1, errors=0.
- Preload stimulus so that bit_errors is near 2^64-1; adding 10 errors -> wraps to 9 relative to all-ones (wrap check).
